// File: rtl/pwm_pkg.sv
// Shared types and default constants for the PWM duty sequencer.
// The slew FSM enum is only used when PWM_SLEW_EN is defined.
package pwm_pkg;
  localparam int unsigned DUTY_W_DEF    = 8;
  localparam int unsigned STEP_DEF      = 16;
  localparam int unsigned DB_CYCLES_DEF = 4;
  localparam int unsigned SLEW_DIV_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SLEW_UP = 2'd1,
    SLEW_DN = 2'd2
  } slew_state_e;
endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// Button/enable inputs and duty/status outputs of the PWM duty sequencer.
interface pwm_duty_sequencer_if
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY_W = DUTY_W_DEF
);
  logic              ena;
  logic              btn_up;
  logic              btn_dn;
  logic [DUTY_W-1:0] duty_o;
  logic [DUTY_W-1:0] target_o;
  logic              busy_o;
  logic              at_max_o;
  logic              at_min_o;

  modport slave (
    input  ena, btn_up, btn_dn,
    output duty_o, target_o, busy_o, at_max_o, at_min_o
  );

  modport master (
    output ena, btn_up, btn_dn,
    input  duty_o, target_o, busy_o, at_max_o, at_min_o
  );
endinterface

// File: rtl/pwm_debounce.sv
// Two-flop synchronizer, stability-window debouncer and registered
// rising-edge pulse for one raw button.
module pwm_debounce
  import pwm_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);
  localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic       db_q, db_d;
  logic       rise_q, rise_d;
  logic [7:0] cnt_q, cnt_d;

  // The pulse is registered on the flip edge so the request lands one edge later.
  always_comb begin
    db_d   = db_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d   = sync2_q;
        rise_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;
endmodule

// File: rtl/pwm_duty_sequencer.sv
// Button-driven duty target with saturating steps; duty follows the target
// directly, or slews 1 LSB per SLEW_DIV clocks when PWM_SLEW_EN is defined.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY_W    = DUTY_W_DEF,
  parameter int unsigned STEP      = STEP_DEF,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned SLEW_DIV  = SLEW_DIV_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  pwm_duty_sequencer_if.slave  seq
);
  localparam logic [DUTY_W:0] STEP_W = (DUTY_W + 1)'(STEP);

  if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_db
    $error("DB_CYCLES out of range 1..255");
  end
  if (SLEW_DIV < 1 || SLEW_DIV > 255) begin : g_bad_div
    $error("SLEW_DIV out of range 1..255");
  end

  logic              up_rise, dn_rise;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W:0]   sum;
  logic              busy;

  pwm_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .rst_n(rst_n), .btn_i(seq.btn_up), .rise_o(up_rise)
  );
  pwm_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .clk(clk), .rst_n(rst_n), .btn_i(seq.btn_dn), .rise_o(dn_rise)
  );

  // Carry out of the widened sum means the step crossed full scale.
  always_comb begin
    sum      = {1'b0, target_q} + STEP_W;
    target_d = target_q;
    if (seq.ena && (up_rise ^ dn_rise)) begin
      if (up_rise) begin
        target_d = sum[DUTY_W] ? '1 : sum[DUTY_W-1:0];
      end else begin
        target_d = ({1'b0, target_q} < STEP_W) ? '0 : target_q - STEP_W[DUTY_W-1:0];
      end
    end
  end

`ifdef PWM_SLEW_EN
  localparam logic [7:0]        DIV_LAST = 8'(SLEW_DIV - 1);
  localparam logic [DUTY_W-1:0] ONE      = DUTY_W'(1);

  slew_state_e state_q, state_d;
  logic [7:0]  div_q, div_d;

  // State is derived from the next duty/target pair, so it always matches the
  // registered relation and a step can never cross the target.
  always_comb begin
    duty_d  = duty_q;
    div_d   = div_q;
    state_d = IDLE;
    if (state_q == IDLE) begin
      div_d = '0;
    end else if (seq.ena) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        duty_d = (state_q == SLEW_UP) ? duty_q + ONE : duty_q - ONE;
      end else begin
        div_d = div_q + 8'd1;
      end
    end
    if (duty_d < target_d)      state_d = SLEW_UP;
    else if (duty_d > target_d) state_d = SLEW_DN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
    end
  end

  assign busy = (state_q != IDLE);
`else
  always_comb begin
    duty_d = seq.ena ? target_q : duty_q;
  end

  assign busy = (duty_q != target_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      duty_q   <= '0;
    end else begin
      target_q <= target_d;
      duty_q   <= duty_d;
    end
  end

  assign seq.duty_o   = duty_q;
  assign seq.target_o = target_q;
  assign seq.busy_o   = busy;
  assign seq.at_max_o = (target_q == '1);
  assign seq.at_min_o = (target_q == '0);
endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer; expectations switch with PWM_SLEW_EN.
module tb_pwm_duty_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic trk = 1'b0;
  logic [7:0] max_duty = '0;

  pwm_duty_sequencer_if #(.DUTY_W(8)) bus ();

  pwm_duty_sequencer #(
    .DUTY_W(8), .STEP(16), .DB_CYCLES(4), .SLEW_DIV(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seq(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!trk) max_duty <= '0;
    else if (bus.duty_o > max_duty) max_duty <= bus.duty_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic up, input logic dn, input int hold);
    @(negedge clk);
    bus.btn_up = up;
    bus.btn_dn = dn;
    repeat (hold) @(negedge clk);
    bus.btn_up = 1'b0;
    bus.btn_dn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_duty(input string tag, input logic [7:0] v, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.duty_o == v) break;
      @(posedge clk); #1;
    end
    chk(tag, 32'(bus.duty_o), 32'(v));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ena = 1'b1;
    bus.btn_up = 1'b0;
    bus.btn_dn = 1'b0;
    #2;
    chk("rst_duty",   32'(bus.duty_o),   0);
    chk("rst_target", 32'(bus.target_o), 0);
    chk("rst_busy",   32'(bus.busy_o),   0);
    chk("rst_at_min", 32'(bus.at_min_o), 1);
    chk("rst_at_max", 32'(bus.at_max_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Held up press: target lands on edge 6.
    bus.btn_up = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("tgt_edge5", 32'(bus.target_o), 0);
    @(posedge clk); #1;
    chk("tgt_edge6", 32'(bus.target_o), 16);
    chk("busy_edge6", 32'(bus.busy_o), 1);
    chk("duty_edge6", 32'(bus.duty_o), 0);
`ifdef PWM_SLEW_EN
    wait_duty("duty_slew16", 8'd16, 80);
`else
    @(posedge clk); #1;
    chk("duty_edge7", 32'(bus.duty_o), 16);
`endif
    chk("busy_done", 32'(bus.busy_o), 0);
    repeat (14) @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (12) @(negedge clk);
    chk("one_per_press", 32'(bus.target_o), 16);

    // 3-clock glitch is shorter than the debounce window.
    bus.btn_up = 1'b1;
    repeat (3) @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch", 32'(bus.target_o), 16);

    bus.ena = 1'b0;
    press(1'b1, 1'b0, 8);
    chk("ena_low_tgt",  32'(bus.target_o), 16);
    chk("ena_low_duty", 32'(bus.duty_o),   16);
    bus.ena = 1'b1;

    press(1'b1, 1'b1, 8);
    chk("both_btn", 32'(bus.target_o), 16);

    press(1'b0, 1'b1, 8);
    chk("down16",    32'(bus.target_o), 0);
    chk("down_min",  32'(bus.at_min_o), 1);
    press(1'b0, 1'b1, 8);
    chk("down_floor", 32'(bus.target_o), 0);
    chk("floor_min",  32'(bus.at_min_o), 1);

    for (int i = 0; i < 16; i++) press(1'b1, 1'b0, 8);
    chk("sat16_tgt", 32'(bus.target_o), 255);
    chk("sat16_max", 32'(bus.at_max_o), 1);
    chk("sat16_min", 32'(bus.at_min_o), 0);
    press(1'b1, 1'b0, 8);
    chk("sat17_tgt", 32'(bus.target_o), 255);
    press(1'b0, 1'b1, 8);
    chk("down255", 32'(bus.target_o), 239);
    chk("down255_max", 32'(bus.at_max_o), 0);

    // Asynchronous reset between edges while duty and target differ.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.btn_up = 1'b1;
    repeat (7) @(posedge clk); #1;
    chk("pre_rst_tgt",  32'(bus.target_o), 16);
    chk("pre_rst_busy", 32'(bus.busy_o),   1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_target", 32'(bus.target_o), 0);
    chk("arst_duty",   32'(bus.duty_o),   0);
    chk("arst_busy",   32'(bus.busy_o),   0);
    chk("arst_at_min", 32'(bus.at_min_o), 1);
    chk("arst_at_max", 32'(bus.at_max_o), 0);
    bus.btn_up = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_tgt", 32'(bus.target_o), 0);

`ifdef PWM_SLEW_EN
    // Redirect a slew toward 32 down to 16 while duty is around 10.
    press(1'b1, 1'b0, 8);
    press(1'b1, 1'b0, 8);
    chk("redir_tgt32", 32'(bus.target_o), 32);
    trk = 1'b1;
    wait_duty("redir_duty10", 8'd10, 100);
    press(1'b0, 1'b1, 8);
    chk("redir_tgt16", 32'(bus.target_o), 16);
    repeat (60) @(negedge clk);
    chk("redir_duty",  32'(bus.duty_o),  16);
    chk("redir_busy",  32'(bus.busy_o),  0);
    chk("redir_max",   32'(max_duty),    16);
    trk = 1'b0;
`else
    press(1'b1, 1'b0, 8);
    press(1'b1, 1'b0, 8);
    chk("follow_tgt32",  32'(bus.target_o), 32);
    chk("follow_duty32", 32'(bus.duty_o),   32);
    press(1'b0, 1'b1, 8);
    chk("follow_duty16", 32'(bus.duty_o),   16);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
